// File: rtl/traj_profile_gen_pkg.sv
// Shared definitions for the trapezoidal profile generator: fixed-point
// format and the profile phase encoding.
package traj_profile_gen_pkg;

  localparam int FRAC_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEL  = 2'd1,
    ST_CRUISE = 2'd2,
    ST_DECEL  = 2'd3
  } state_t;

endpackage

// File: rtl/traj_profile_gen_tick_gen.sv
// Profile-rate prescaler: one-cycle tick every TICK_DIV clocks, realigned by
// i_restart so the first tick after a start lands exactly TICK_DIV cycles later.
module tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_restart) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/traj_profile_gen.sv
// Trapezoidal setpoint generator feeding the PID: ramps P toward the latched
// target with bounded acceleration and velocity, snapping exactly onto it.
module traj_profile_gen
  import traj_profile_gen_pkg::*;
#(
  parameter int POS_W    = 13,
  parameter int VEL_W    = 16,
  parameter int TICK_DIV = 50000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [POS_W-1:0] i_target,
  input  logic [VEL_W-1:0] i_vmax,
  input  logic [VEL_W-1:0] i_accel,
  output logic [15:0]      o_setpoint,
  output logic [VEL_W-1:0] o_velocity,
  output logic             o_dir,
  output logic             o_busy,
  output logic             o_done
);

  localparam int PW = POS_W + FRAC_BITS;
  localparam int EW = (PW > VEL_W + 1) ? PW : VEL_W + 1;

  state_t           r_state, w_state_nx;
  logic [PW-1:0]    r_p, r_t, r_dacc;
  logic [VEL_W-1:0] r_v, r_vmax, r_a;
  logic             r_dir, r_done;

  logic             w_tick, w_accept, w_zero, w_arrive;
  logic [PW-1:0]    w_t_new, w_r;
  logic [VEL_W:0]   w_v_add;
  logic [VEL_W-1:0] w_v_up, w_v_dn, w_v_nx;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_restart(w_accept),
    .o_tick   (w_tick)
  );

  assign w_accept = (r_state == ST_IDLE) && i_start;
  assign w_t_new  = {i_target, {FRAC_BITS{1'b0}}};
  assign w_zero   = (i_accel == '0) || (i_vmax == '0) || (w_t_new == r_p);
  assign w_r      = r_dir ? (r_p - r_t) : (r_t - r_p);

  assign w_v_add = {1'b0, r_v} + {1'b0, r_a};
  assign w_v_up  = (w_v_add >= {1'b0, r_vmax}) ? r_vmax : w_v_add[VEL_W-1:0];
  // Deceleration never drops below A, so the final approach cannot stall.
  assign w_v_dn  = ({1'b0, r_v} > {r_a, 1'b0}) ? (r_v - r_a) : r_a;

  always_comb begin
    w_state_nx = r_state;
    w_v_nx     = r_v;
    case (r_state)
      ST_ACCEL: begin
        if (r_dacc >= w_r) begin
          w_state_nx = ST_DECEL;
          w_v_nx     = w_v_dn;
        end else begin
          w_v_nx = w_v_up;
          if (w_v_up == r_vmax) w_state_nx = ST_CRUISE;
        end
      end
      ST_CRUISE: begin
        if (r_dacc >= w_r) begin
          w_state_nx = ST_DECEL;
          w_v_nx     = w_v_dn;
        end
      end
      ST_DECEL: w_v_nx = w_v_dn;
      default:  w_v_nx = r_v;
    endcase
  end

  assign w_arrive = (EW'(w_r) <= EW'(w_v_nx));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_p     <= '0;
      r_t     <= '0;
      r_dacc  <= '0;
      r_v     <= '0;
      r_vmax  <= '0;
      r_a     <= '0;
      r_dir   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_t    <= w_t_new;
        r_vmax <= i_vmax;
        r_a    <= i_accel;
        r_dir  <= (w_t_new < r_p);
        r_dacc <= '0;
        r_v    <= '0;
        if (w_zero) r_done  <= 1'b1;
        else        r_state <= ST_ACCEL;
      end else if (w_tick && (r_state != ST_IDLE)) begin
        if (r_state == ST_ACCEL) r_dacc <= r_dacc + PW'(w_v_nx);
        if (w_arrive) begin
          r_p     <= r_t;
          r_v     <= '0;
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
        end else begin
          r_p     <= r_dir ? (r_p - PW'(w_v_nx)) : (r_p + PW'(w_v_nx));
          r_v     <= w_v_nx;
          r_state <= w_state_nx;
        end
      end
    end
  end

  assign o_setpoint = 16'(r_p[PW-1:FRAC_BITS]);
  assign o_velocity = r_v;
  assign o_dir      = r_dir;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = r_done;

endmodule

// File: tb/tb_traj_profile_gen.sv
// Bench for traj_profile_gen: directed scenarios plus random moves, every tick
// compared against a plain-arithmetic trajectory model.
module tb_traj_profile_gen;

  localparam int POS_W    = 13;
  localparam int VEL_W    = 16;
  localparam int TICK_DIV = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [POS_W-1:0] target;
  logic [VEL_W-1:0] vmax, accel;
  logic [15:0]      setpoint;
  logic [VEL_W-1:0] velocity;
  logic             dir, busy, done;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v_q[$];
  int model_p;

  always #5 clk = ~clk;

  traj_profile_gen #(.POS_W(POS_W), .VEL_W(VEL_W), .TICK_DIV(TICK_DIV)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_target  (target),
    .i_vmax    (vmax),
    .i_accel   (accel),
    .o_setpoint(setpoint),
    .o_velocity(velocity),
    .o_dir     (dir),
    .o_busy    (busy),
    .o_done    (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Trajectory model: positions/velocities in Q.8 integers, one entry per tick.
  task automatic model_move(input int p0, input int tgt, input int vm, input int a,
                            output bit zero);
    int t, p, v, vn, dacc, r;
    bit dn, cruising, mv_dir;
    exp_q.delete();
    exp_v_q.delete();
    t = tgt * 256;
    p = p0;
    v = 0;
    dacc = 0;
    dn = 0;
    cruising = 0;
    mv_dir = (t < p);
    zero = (a == 0) || (vm == 0) || (t == p);
    if (zero) return;
    for (int k = 0; k < 20000; k++) begin
      r = mv_dir ? p - t : t - p;
      if (!dn && r <= dacc) dn = 1;
      if (dn) begin
        vn = v - a;
        if (vn < a) vn = a;
      end else if (!cruising) begin
        vn = v + a;
        if (vn > vm) vn = vm;
        dacc += vn;
        if (vn == vm) cruising = 1;
      end else begin
        vn = v;
      end
      if (r <= vn) begin
        exp_q.push_back(t);
        exp_v_q.push_back(0);
        break;
      end
      p = mv_dir ? p - vn : p + vn;
      v = vn;
      exp_q.push_back(p);
      exp_v_q.push_back(v);
    end
  endtask

  task automatic run_move(input string tag, input int tgt, input int vm, input int a,
                          input int inject_at);
    bit zero, exp_dir;
    int prev_sp, cyc, p, v;
    model_move(model_p, tgt, vm, a, zero);
    exp_dir = (tgt * 256 < model_p);
    prev_sp = model_p / 256;
    target = tgt[POS_W-1:0];
    vmax   = vm[VEL_W-1:0];
    accel  = a[VEL_W-1:0];
    start  = 1'b1;
    step();
    start = 1'b0;
    check_eq({tag, ":dir"}, dir, exp_dir);
    if (zero) begin
      check_eq({tag, ":zero_done"}, done, 1);
      check_eq({tag, ":zero_busy"}, busy, 0);
      check_eq({tag, ":zero_sp"}, setpoint, prev_sp);
      step();
      check_eq({tag, ":zero_done_end"}, done, 0);
      check_eq({tag, ":zero_busy_end"}, busy, 0);
      return;
    end
    check_eq({tag, ":busy_rise"}, busy, 1);
    check_eq({tag, ":done_low"}, done, 0);
    cyc = 0;
    while (exp_q.size() > 0) begin
      p = exp_q.pop_front();
      v = exp_v_q.pop_front();
      repeat (TICK_DIV - 1) begin
        cyc++;
        if (cyc == inject_at) begin
          start  = 1'b1;
          target = POS_W'($urandom_range(0, 500));
          vmax   = VEL_W'($urandom_range(1, 1024));
          accel  = VEL_W'($urandom_range(1, 256));
        end
        step();
        start = 1'b0;
        check_eq({tag, ":hold_sp"}, setpoint, prev_sp);
        check_eq({tag, ":hold_busy"}, busy, 1);
        check_eq({tag, ":hold_done"}, done, 0);
      end
      step();
      check_eq({tag, ":tick_sp"}, setpoint, p / 256);
      check_eq({tag, ":tick_vel"}, velocity, v);
      if (exp_q.size() == 0) begin
        check_eq({tag, ":arrive_busy"}, busy, 0);
        check_eq({tag, ":arrive_done"}, done, 1);
      end else begin
        check_eq({tag, ":run_busy"}, busy, 1);
        check_eq({tag, ":run_done"}, done, 0);
      end
      prev_sp = p / 256;
    end
    step();
    check_eq({tag, ":done_pulse_end"}, done, 0);
    check_eq({tag, ":final_sp"}, setpoint, tgt);
    model_p = tgt * 256;
  endtask

  initial begin
    int tgt, vm, a;
    rst    = 1'b1;
    start  = 1'b0;
    target = '0;
    vmax   = '0;
    accel  = '0;
    repeat (3) step();
    rst = 1'b0;
    check_eq("reset:sp", setpoint, 0);
    check_eq("reset:vel", velocity, 0);
    check_eq("reset:dir", dir, 0);
    check_eq("reset:busy", busy, 0);
    check_eq("reset:done", done, 0);
    model_p = 0;

    run_move("t1_cruise", 100, 16'h0200, 16'h0080, 0);
    run_move("t3_down", 20, 16'h0200, 16'h0080, 0);
    run_move("t4_ignore", 200, 16'h0200, 16'h0080, 7);
    run_move("t4_acc0", 50, 16'h0200, 0, 0);
    run_move("t6_same", model_p / 256, 16'h0200, 16'h0080, 0);

    // Reset in the middle of a cruise phase.
    target = 13'd300;
    vmax   = 16'h0200;
    accel  = 16'h0080;
    start  = 1'b1;
    step();
    start = 1'b0;
    repeat (6 * TICK_DIV) step();
    check_eq("t5:cruise_vel", velocity, 16'h0200);
    check_eq("t5:cruise_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("t5:rst_sp", setpoint, 0);
    check_eq("t5:rst_busy", busy, 0);
    check_eq("t5:rst_vel", velocity, 0);
    check_eq("t5:rst_done", done, 0);
    model_p = 0;

    run_move("t2_tri", 3, 16'h0200, 16'h0080, 0);

    for (int i = 0; i < 12; i++) begin
      tgt = $urandom_range(0, 300);
      vm  = $urandom_range(192, 1024);
      a   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(16, 256);
      run_move("rand", tgt, vm, a, $urandom_range(1, 20));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
